multicycle_ctrl: RTL

Main control FSM for the multicycle MIPS datapath. It sequences fetch, decode, execute, memory and writeback over several clock cycles, and drives the ALUOp code consumed by the ALU control decoder. It handshakes with a variable-latency memory (mem_ready) and with the multiply/divide unit (md_start/md_done). It counts retired instructions and flags illegal opcodes and mul/div timeouts.

---
 rtl/mips_pkg.sv | 48 ++++
 rtl/multicycle_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, ALU/mux selects
// and the 4-bit main-FSM state codes.
package mips_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  // MULT/MULTU/DIV/DIVU share funct 0110xx
  localparam logic [5:0] FN_MD_MASK = 6'b111100;
  localparam logic [5:0] FN_MD_VAL  = 6'b011000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REGB   = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_RD    = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WR    = 4'd5;
  localparam logic [3:0] S_R_EXEC    = 4'd6;
  localparam logic [3:0] S_R_WB      = 4'd7;
  localparam logic [3:0] S_BRANCH    = 4'd8;
  localparam logic [3:0] S_JUMP      = 4'd9;
  localparam logic [3:0] S_ADDI_EXEC = 4'd10;
  localparam logic [3:0] S_ADDI_WB   = 4'd11;
  localparam logic [3:0] S_MD_WAIT   = 4'd12;
  localparam logic [3:0] S_ILLEGAL   = 4'd13;

  function automatic logic is_muldiv(input logic [5:0] fn);
    return (fn & FN_MD_MASK) == FN_MD_VAL;
  endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS datapath: sequences each instruction,
// handshakes with memory and the mul/div unit, and counts retired instructions.
module multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int MD_TIMEOUT = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  input  logic             md_done,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             md_start,
  output logic             illegal_op,
  output logic             md_fault,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] instr_count
);

  localparam int WC_W = $clog2(MD_TIMEOUT) + 1;

  logic [3:0]      state, state_nxt;
  logic [WC_W-1:0] wcnt;
  logic            retire;
  logic            md_expire;
  logic            unused_zero;

  // The branch decision is taken in the datapath from pc_write_cond & zero.
  assign unused_zero = zero;
  assign state_o     = state;
  assign md_expire   = (state == S_MD_WAIT) && !md_done && (wcnt == WC_W'(MD_TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    retire    = 1'b0;
    case (state)
      S_FETCH:     if (mem_ready) state_nxt = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_nxt = S_MEM_ADDR;
          OP_R:         state_nxt = S_R_EXEC;
          OP_BEQ:       state_nxt = S_BRANCH;
          OP_J:         state_nxt = S_JUMP;
          OP_ADDI:      state_nxt = S_ADDI_EXEC;
          default:      state_nxt = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR:  state_nxt = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:    if (mem_ready) state_nxt = S_MEM_WB;
      S_MEM_WR: begin
        if (mem_ready) begin
          state_nxt = S_FETCH;
          retire    = 1'b1;
        end
      end
      S_R_EXEC:    state_nxt = is_muldiv(funct) ? S_MD_WAIT : S_R_WB;
      S_ADDI_EXEC: state_nxt = S_ADDI_WB;
      S_MD_WAIT: begin
        // md_done wins over the timeout on the final wait cycle
        if (md_done) begin
          state_nxt = S_FETCH;
          retire    = 1'b1;
        end else if (md_expire) begin
          state_nxt = S_FETCH;
        end
      end
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: begin
        state_nxt = S_FETCH;
        retire    = 1'b1;
      end
      default:     state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_FETCH;
      wcnt        <= '0;
      instr_count <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_MD_WAIT && state_nxt == S_MD_WAIT)
        wcnt <= wcnt + WC_W'(1);
      else
        wcnt <= '0;
      if (retire)
        instr_count <= instr_count + CNT_W'(1);
    end
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REGB;
    alu_op        = ALUOP_ADD;
    pc_source     = PCSRC_ALU;
    md_start      = 1'b0;
    illegal_op    = 1'b0;
    md_fault      = md_expire;
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE:    alu_src_b = SRCB_IMM_SH;
      S_MEM_ADDR, S_ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
        md_start  = is_muldiv(funct);
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
      end
      S_ADDI_WB:   reg_write = 1'b1;
      S_ILLEGAL:   illegal_op = 1'b1;
      default: ;
    endcase
  end

endmodule
